// File: rtl/id_stage_pipe.sv
// RV32I decode stage: register file, immediate/control decode and a registered ID/EX slot
// with valid/ready handshake, load-use stall, flush and WB->ID write-through bypass.
module id_stage_pipe #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREG      = 32,
  parameter bit          WB_BYPASS = 1'b1,
  localparam int unsigned RAW      = $clog2(NREG)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clk_en,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_flush,
  input  logic            i_ex_ready,
  input  logic            i_ex_load,
  input  logic [RAW-1:0]  i_ex_rd,
  input  logic            i_wb_wr_en,
  input  logic [RAW-1:0]  i_wb_addr,
  input  logic [XLEN-1:0] i_wb_data,
  output logic            o_out_valid,
  output logic [XLEN-1:0] o_out_pc,
  output logic [XLEN-1:0] o_out_rs1,
  output logic [XLEN-1:0] o_out_rs2,
  output logic [XLEN-1:0] o_out_imm,
  output logic [RAW-1:0]  o_out_rd,
  output logic            o_out_rd_wr_en,
  output logic [6:0]      o_out_opcode,
  output logic [2:0]      o_out_funct3,
  output logic            o_out_funct7b5,
  output logic            o_out_cond_jump,
  output logic            o_out_uncond_jump,
  output logic            o_out_base_sel,
  output logic            o_out_illegal
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  // Architectural state
  logic [XLEN-1:0] r_regs [NREG];

  // ID/EX output slot
  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  logic [XLEN-1:0] r_imm;
  logic [RAW-1:0]  r_rd;
  logic            r_rd_wr_en;
  logic [6:0]      r_opcode;
  logic [2:0]      r_funct3;
  logic            r_funct7b5;
  logic            r_cond_jump;
  logic            r_uncond_jump;
  logic            r_base_sel;
  logic            r_illegal;

  // Field extraction
  logic [6:0]      w_opcode;
  logic [RAW-1:0]  w_rd;
  logic [RAW-1:0]  w_rs1;
  logic [RAW-1:0]  w_rs2;

  assign w_opcode = i_inst[6:0];
  assign w_rd     = i_inst[7 +: RAW];
  assign w_rs1    = i_inst[15 +: RAW];
  assign w_rs2    = i_inst[20 +: RAW];

  // Control decode
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_rs1_used;
  logic            w_rs2_used;
  logic            w_rd_wr;
  logic            w_cond_jump;
  logic            w_uncond_jump;
  logic            w_base_sel;
  logic            w_illegal;

  always_comb begin
    w_imm32       = '0;
    w_rs1_used    = 1'b1;
    w_rs2_used    = 1'b0;
    w_rd_wr       = 1'b0;
    w_cond_jump   = 1'b0;
    w_uncond_jump = 1'b0;
    w_base_sel    = 1'b0;
    w_illegal     = 1'b0;
    case (w_opcode)
      OpLui, OpAuipc: begin
        w_imm32    = {i_inst[31:12], 12'b0};
        w_rs1_used = 1'b0;
        w_rd_wr    = 1'b1;
      end
      OpJal: begin
        w_imm32       = {{12{i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
        w_rs1_used    = 1'b0;
        w_rd_wr       = 1'b1;
        w_uncond_jump = 1'b1;
      end
      OpJalr: begin
        w_imm32       = {{20{i_inst[31]}}, i_inst[31:20]};
        w_rd_wr       = 1'b1;
        w_uncond_jump = 1'b1;
        w_base_sel    = 1'b1;
      end
      OpBranch: begin
        w_imm32     = {{20{i_inst[31]}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
        w_rs2_used  = 1'b1;
        w_cond_jump = 1'b1;
      end
      OpLoad, OpImm: begin
        w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
        w_rd_wr = 1'b1;
      end
      OpStore: begin
        w_imm32    = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
        w_rs2_used = 1'b1;
      end
      OpReg: begin
        w_rs2_used = 1'b1;
        w_rd_wr    = 1'b1;
      end
      OpFence, OpSystem: begin
        w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  assign w_imm = XLEN'($signed(w_imm32));

  // Register read with optional same-cycle write-back forwarding
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;

  always_comb begin
    if (w_rs1 == '0) begin
      w_rs1_data = '0;
    end else if (WB_BYPASS && i_wb_wr_en && (i_wb_addr == w_rs1)) begin
      w_rs1_data = i_wb_data;
    end else begin
      w_rs1_data = r_regs[w_rs1];
    end
    if (w_rs2 == '0) begin
      w_rs2_data = '0;
    end else if (WB_BYPASS && i_wb_wr_en && (i_wb_addr == w_rs2)) begin
      w_rs2_data = i_wb_data;
    end else begin
      w_rs2_data = r_regs[w_rs2];
    end
  end

  // Load-use hazard: the load result is not yet available to forward
  logic w_hazard;
  logic w_accept;

  assign w_hazard = i_ex_load && (i_ex_rd != '0) &&
                    ((w_rs1_used && (w_rs1 == i_ex_rd)) || (w_rs2_used && (w_rs2 == i_ex_rd)));

  assign o_in_ready = i_clk_en && !i_rst && !i_flush && !w_hazard &&
                      (!r_valid || i_ex_ready);
  assign w_accept   = i_in_valid && o_in_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_valid       <= 1'b0;
      r_pc          <= '0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_imm         <= '0;
      r_rd          <= '0;
      r_rd_wr_en    <= 1'b0;
      r_opcode      <= '0;
      r_funct3      <= '0;
      r_funct7b5    <= 1'b0;
      r_cond_jump   <= 1'b0;
      r_uncond_jump <= 1'b0;
      r_base_sel    <= 1'b0;
      r_illegal     <= 1'b0;
    end else if (i_clk_en) begin
      if (i_wb_wr_en && (i_wb_addr != '0)) begin
        r_regs[i_wb_addr] <= i_wb_data;
      end
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid       <= 1'b1;
        r_pc          <= i_pc;
        r_rs1         <= w_rs1_data;
        r_rs2         <= w_rs2_data;
        r_imm         <= w_imm;
        r_rd          <= w_rd;
        r_rd_wr_en    <= w_rd_wr && (w_rd != '0);
        r_opcode      <= w_opcode;
        r_funct3      <= i_inst[14:12];
        r_funct7b5    <= i_inst[30];
        r_cond_jump   <= w_cond_jump;
        r_uncond_jump <= w_uncond_jump;
        r_base_sel    <= w_base_sel;
        r_illegal     <= w_illegal;
      end else if (r_valid && i_ex_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_out_valid       = r_valid;
  assign o_out_pc          = r_pc;
  assign o_out_rs1         = r_rs1;
  assign o_out_rs2         = r_rs2;
  assign o_out_imm         = r_imm;
  assign o_out_rd          = r_rd;
  assign o_out_rd_wr_en    = r_rd_wr_en;
  assign o_out_opcode      = r_opcode;
  assign o_out_funct3      = r_funct3;
  assign o_out_funct7b5    = r_funct7b5;
  assign o_out_cond_jump   = r_cond_jump;
  assign o_out_uncond_jump = r_uncond_jump;
  assign o_out_base_sel    = r_base_sel;
  assign o_out_illegal     = r_illegal;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: expected decode results are queued when an instruction
// is presented and compared when it appears on the ID/EX outputs.
module tb_id_stage_pipe;

  logic        i_clk;
  logic        i_rst;
  logic        i_clk_en;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [31:0] i_inst;
  logic [31:0] i_pc;
  logic        i_flush;
  logic        i_ex_ready;
  logic        i_ex_load;
  logic [4:0]  i_ex_rd;
  logic        i_wb_wr_en;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        o_out_valid;
  logic [31:0] o_out_pc;
  logic [31:0] o_out_rs1;
  logic [31:0] o_out_rs2;
  logic [31:0] o_out_imm;
  logic [4:0]  o_out_rd;
  logic        o_out_rd_wr_en;
  logic [6:0]  o_out_opcode;
  logic [2:0]  o_out_funct3;
  logic        o_out_funct7b5;
  logic        o_out_cond_jump;
  logic        o_out_uncond_jump;
  logic        o_out_base_sel;
  logic        o_out_illegal;

  id_stage_pipe #(
    .XLEN      (32),
    .NREG      (32),
    .WB_BYPASS (1'b1)
  ) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_clk_en          (i_clk_en),
    .i_in_valid        (i_in_valid),
    .o_in_ready        (o_in_ready),
    .i_inst            (i_inst),
    .i_pc              (i_pc),
    .i_flush           (i_flush),
    .i_ex_ready        (i_ex_ready),
    .i_ex_load         (i_ex_load),
    .i_ex_rd           (i_ex_rd),
    .i_wb_wr_en        (i_wb_wr_en),
    .i_wb_addr         (i_wb_addr),
    .i_wb_data         (i_wb_data),
    .o_out_valid       (o_out_valid),
    .o_out_pc          (o_out_pc),
    .o_out_rs1         (o_out_rs1),
    .o_out_rs2         (o_out_rs2),
    .o_out_imm         (o_out_imm),
    .o_out_rd          (o_out_rd),
    .o_out_rd_wr_en    (o_out_rd_wr_en),
    .o_out_opcode      (o_out_opcode),
    .o_out_funct3      (o_out_funct3),
    .o_out_funct7b5    (o_out_funct7b5),
    .o_out_cond_jump   (o_out_cond_jump),
    .o_out_uncond_jump (o_out_uncond_jump),
    .o_out_base_sel    (o_out_base_sel),
    .o_out_illegal     (o_out_illegal)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic        rd_wr;
    logic        cond;
    logic        uncond;
    logic        base;
    logic        illegal;
    logic        chk_rs1;
    logic        chk_rs2;
    logic        chk_imm;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] rs1,
                              input logic [31:0] rs2, input logic [31:0] imm,
                              input logic [4:0] rd, input logic [6:0] opcode,
                              input logic rd_wr, input logic cond, input logic uncond,
                              input logic base, input logic illegal, input logic chk_rs1,
                              input logic chk_rs2, input logic chk_imm);
    exp_t e;
    e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.rd = rd; e.opcode = opcode;
    e.rd_wr = rd_wr; e.cond = cond; e.uncond = uncond; e.base = base; e.illegal = illegal;
    e.chk_rs1 = chk_rs1; e.chk_rs2 = chk_rs2; e.chk_imm = chk_imm;
    return e;
  endfunction

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, ".valid"}, {31'd0, o_out_valid}, 32'd1);
      chk({tag, ".pc"}, o_out_pc, e.pc);
      chk({tag, ".opcode"}, {25'd0, o_out_opcode}, {25'd0, e.opcode});
      chk({tag, ".rd_wr_en"}, {31'd0, o_out_rd_wr_en}, {31'd0, e.rd_wr});
      chk({tag, ".cond"}, {31'd0, o_out_cond_jump}, {31'd0, e.cond});
      chk({tag, ".uncond"}, {31'd0, o_out_uncond_jump}, {31'd0, e.uncond});
      chk({tag, ".base_sel"}, {31'd0, o_out_base_sel}, {31'd0, e.base});
      chk({tag, ".illegal"}, {31'd0, o_out_illegal}, {31'd0, e.illegal});
      if (e.chk_imm) chk({tag, ".imm"}, o_out_imm, e.imm);
      if (e.chk_rs1) chk({tag, ".rs1"}, o_out_rs1, e.rs1);
      if (e.chk_rs2) chk({tag, ".rs2"}, o_out_rs2, e.rs2);
      if (e.rd_wr) chk({tag, ".rd"}, {27'd0, o_out_rd}, {27'd0, e.rd});
    end
  endtask

  // Present an instruction in the low phase, expect it to be taken at the next edge.
  task automatic accept(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                        input exp_t e);
    i_inst     = inst;
    i_pc       = pc;
    i_in_valid = 1'b1;
    #1;
    chk({tag, ".in_ready"}, {31'd0, o_in_ready}, 32'd1);
    sb.push_back(e);
    @(posedge i_clk);
    #1;
    check_out(tag);
    @(negedge i_clk);
    i_in_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] addr, input logic [31:0] data);
    i_wb_wr_en = 1'b1;
    i_wb_addr  = addr;
    i_wb_data  = data;
    @(posedge i_clk);
    @(negedge i_clk);
    i_wb_wr_en = 1'b0;
  endtask

  initial begin
    i_rst      = 1'b1;
    i_clk_en   = 1'b1;
    i_in_valid = 1'b0;
    i_inst     = '0;
    i_pc       = '0;
    i_flush    = 1'b0;
    i_ex_ready = 1'b1;
    i_ex_load  = 1'b0;
    i_ex_rd    = '0;
    i_wb_wr_en = 1'b0;
    i_wb_addr  = '0;
    i_wb_data  = '0;

    // Reset state
    @(negedge i_clk);
    i_in_valid = 1'b1;
    #1;
    chk("rst.in_ready", {31'd0, o_in_ready}, 32'd0);
    i_in_valid = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    chk("rst.out_valid", {31'd0, o_out_valid}, 32'd0);
    chk("rst.out_pc", o_out_pc, 32'd0);
    chk("rst.out_imm", o_out_imm, 32'd0);
    chk("rst.out_rd_wr_en", {31'd0, o_out_rd_wr_en}, 32'd0);
    chk("rst.in_ready_after", {31'd0, o_in_ready}, 32'd1);

    // ADDI x2,x1,-3 after x1 <= 5
    wb(5'd1, 32'd5);
    accept("addi", 32'hFFD08113, 32'h100,
           mk(32'h100, 32'd5, 32'd0, 32'hFFFFFFFD, 5'd2, 7'h13, 1, 0, 0, 0, 0, 1, 0, 1));

    // ADD x4,x3,x3 while x3 <= 0xAA is being written back
    i_wb_wr_en = 1'b1;
    i_wb_addr  = 5'd3;
    i_wb_data  = 32'hAA;
    accept("add_bypass", 32'h00318233, 32'h104,
           mk(32'h104, 32'hAA, 32'hAA, 32'd0, 5'd4, 7'h33, 1, 0, 0, 0, 0, 1, 1, 0));
    i_wb_wr_en = 1'b0;

    // Load-use hazard on x5
    i_ex_load  = 1'b1;
    i_ex_rd    = 5'd5;
    i_inst     = 32'h00028333;
    i_pc       = 32'h108;
    i_in_valid = 1'b1;
    #1;
    chk("hazard.in_ready", {31'd0, o_in_ready}, 32'd0);
    @(posedge i_clk);
    #1;
    chk("hazard.bubble", {31'd0, o_out_valid}, 32'd0);
    @(negedge i_clk);
    i_ex_load = 1'b0;
    accept("add_after_hazard", 32'h00028333, 32'h108,
           mk(32'h108, 32'd0, 32'd0, 32'd0, 5'd6, 7'h33, 1, 0, 0, 0, 0, 1, 1, 0));

    // Back-pressure for 3 cycles holds the ADD x6
    i_ex_ready = 1'b0;
    i_inst     = 32'h123453B7;
    i_pc       = 32'h10C;
    i_in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall.in_ready", {31'd0, o_in_ready}, 32'd0);
      @(posedge i_clk);
      #1;
      chk("stall.out_valid", {31'd0, o_out_valid}, 32'd1);
      chk("stall.out_pc", o_out_pc, 32'h108);
      chk("stall.out_rd", {27'd0, o_out_rd}, 32'd6);
      @(negedge i_clk);
    end
    i_ex_ready = 1'b1;
    accept("lui", 32'h123453B7, 32'h10C,
           mk(32'h10C, 32'd0, 32'd0, 32'h12345000, 5'd7, 7'h37, 1, 0, 0, 0, 0, 0, 0, 1));

    // Flush kills the held LUI and blocks the JALR that cycle
    i_ex_ready = 1'b0;
    i_flush    = 1'b1;
    i_inst     = 32'h008100E7;
    i_pc       = 32'h110;
    i_in_valid = 1'b1;
    #1;
    chk("flush.in_ready", {31'd0, o_in_ready}, 32'd0);
    @(posedge i_clk);
    #1;
    chk("flush.out_valid", {31'd0, o_out_valid}, 32'd0);
    @(negedge i_clk);
    i_flush    = 1'b0;
    i_ex_ready = 1'b1;
    accept("jalr", 32'h008100E7, 32'h110,
           mk(32'h110, 32'd0, 32'd0, 32'd8, 5'd1, 7'h67, 1, 0, 1, 1, 0, 1, 0, 1));

    accept("beq", 32'hFE000EE3, 32'h114,
           mk(32'h114, 32'd0, 32'd0, 32'hFFFFFFFC, 5'd0, 7'h63, 0, 1, 0, 0, 0, 1, 1, 1));
    accept("sw", 32'hFE30AC23, 32'h118,
           mk(32'h118, 32'd5, 32'hAA, 32'hFFFFFFF8, 5'd0, 7'h23, 0, 0, 0, 0, 0, 1, 1, 1));
    accept("illegal", 32'h1234507F, 32'h11C,
           mk(32'h11C, 32'd0, 32'd0, 32'd0, 5'd0, 7'h7F, 0, 0, 0, 0, 1, 0, 0, 1));

    // Clock enable low: nothing moves, write-back to x9 is dropped
    i_clk_en   = 1'b0;
    i_wb_wr_en = 1'b1;
    i_wb_addr  = 5'd9;
    i_wb_data  = 32'h77;
    i_inst     = 32'h00048513;
    i_pc       = 32'h120;
    i_in_valid = 1'b1;
    #1;
    chk("clken.in_ready", {31'd0, o_in_ready}, 32'd0);
    @(posedge i_clk);
    #1;
    chk("clken.out_valid", {31'd0, o_out_valid}, 32'd1);
    chk("clken.out_illegal", {31'd0, o_out_illegal}, 32'd1);
    @(negedge i_clk);
    i_clk_en   = 1'b1;
    i_wb_wr_en = 1'b0;
    accept("addi_x9", 32'h00048513, 32'h120,
           mk(32'h120, 32'd0, 32'd0, 32'd0, 5'd10, 7'h13, 1, 0, 0, 0, 0, 1, 0, 1));

    // x0 stays zero: stored write then simultaneous write with read
    wb(5'd0, 32'h55);
    i_wb_wr_en = 1'b1;
    i_wb_addr  = 5'd0;
    i_wb_data  = 32'h55;
    accept("x0_read", 32'h00100113, 32'h124,
           mk(32'h124, 32'd0, 32'd0, 32'd1, 5'd2, 7'h13, 1, 0, 0, 0, 0, 1, 0, 1));
    i_wb_wr_en = 1'b0;

    // Async reset with an instruction still in the output slot
    #2;
    i_rst = 1'b1;
    #1;
    chk("arst.out_valid", {31'd0, o_out_valid}, 32'd0);
    chk("arst.out_pc", o_out_pc, 32'd0);
    chk("arst.in_ready", {31'd0, o_in_ready}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    accept("addi_after_rst", 32'hFFD08113, 32'h200,
           mk(32'h200, 32'd0, 32'd0, 32'hFFFFFFFD, 5'd2, 7'h13, 1, 0, 0, 0, 0, 1, 0, 1));

    chk("sb.drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
